pattern_gen: RTL

//   Parametrised AXI4-Stream video test-pattern source; successor to the fixed 24-bit ramp generator.

---
 rtl/pattern_gen_pkg.sv | 21 ++
 rtl/pattern_gen_pixel.sv | 63 ++++++
 rtl/pattern_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared mode/state types and the colour-bar table used by pattern_gen.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_BORDER = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // {R, G, B} per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/pattern_gen_pixel.sv
// pattern_gen_pixel: purely combinational colour function mapping scan position and
// latched pattern settings to one pixel (ch0=B, ch1=G, ch2=R, optional ch3=alpha).
module pattern_gen_pixel
  import pattern_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8,
  parameter int CNT_W  = 16
) (
  input  mode_e                    mode,
  input  logic [CNT_W-1:0]         h_cnt,
  input  logic [CNT_W-1:0]         v_cnt,
  input  logic [CNT_W-1:0]         h_last,
  input  logic [CNT_W-1:0]         v_last,
  input  logic [2:0]               bar_idx,
  input  logic [CH_W-1:0]          frame_cnt,
  input  logic [NUM_CH*CH_W-1:0]   solid_color,
  output logic [NUM_CH*CH_W-1:0]   pixel
);
  localparam logic [CH_W-1:0] CH_MAX = '1;

  logic [2:0][CH_W-1:0] rgb_ch;
  logic [2:0]           bar_rgb;
  logic                 on_border;

  assign on_border = (h_cnt == '0) || (h_cnt == h_last) ||
                     (v_cnt == '0) || (v_cnt == v_last);
  assign bar_rgb   = BAR_RGB[bar_idx];

  always_comb begin
    rgb_ch = '0;
    case (mode)
      MODE_RAMP: begin
        rgb_ch[0] = h_cnt[CH_W-1:0];
        rgb_ch[1] = v_cnt[CH_W-1:0];
        rgb_ch[2] = frame_cnt;
      end
      MODE_BORDER: begin
        rgb_ch[0] = on_border ? CH_MAX : '0;
        rgb_ch[1] = on_border ? CH_MAX : '0;
        rgb_ch[2] = on_border ? CH_MAX : '0;
      end
      MODE_BARS: begin
        rgb_ch[0] = bar_rgb[0] ? CH_MAX : '0;
        rgb_ch[1] = bar_rgb[1] ? CH_MAX : '0;
        rgb_ch[2] = bar_rgb[2] ? CH_MAX : '0;
      end
      default: rgb_ch = '0;
    endcase
  end

  // Alpha is transparent for the ramp and opaque for the generated colour patterns
  generate
    if (NUM_CH == 4) begin : g_alpha
      logic [CH_W-1:0] alpha;
      assign alpha = (mode == MODE_RAMP) ? '0 : CH_MAX;
      assign pixel = (mode == MODE_SOLID) ? solid_color : {alpha, rgb_ch};
    end else begin : g_rgb
      assign pixel = (mode == MODE_SOLID) ? solid_color : rgb_ch;
    end
  endgenerate

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: AXI4-Stream video test-pattern source, one h_res x v_res frame per accepted sof.
// Optional macro PATTERN_GEN_CONTINUOUS_EN adds the `continuous` input for back-to-back frames.
//
// state | meaning
// IDLE  | waiting for sof with non-zero h_res and v_res
// RUN   | streaming the latched frame; leaves when the final beat is accepted
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [CNT_W-1:0]       h_res,
  input  logic [CNT_W-1:0]       v_res,
  input  logic [1:0]             mode,
  input  logic [NUM_CH*CH_W-1:0] solid_color,
`ifdef PATTERN_GEN_CONTINUOUS_EN
  input  logic                   continuous,
`endif
  input  logic                   sof,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   pix_tvalid,
  input  logic                   pix_tready,
  output logic [NUM_CH*CH_W-1:0] pix_tdata,
  output logic                   pix_tlast,
  output logic                   pix_tuser
);
  localparam int PIX_W = NUM_CH * CH_W;

  state_e state, state_nxt;

  logic cfg_ok;
  logic cont_req;
  logic accept;
  logic start;
  logic restart;
  logic frame_end;
  logic load;

  // Frame settings captured at frame start
  mode_e            mode_q;
  logic [PIX_W-1:0] solid_q;
  logic [CNT_W-1:0] h_last_q;
  logic [CNT_W-1:0] v_last_q;
  logic [CNT_W-1:0] bar_w_m1_q;

  // Scan position of the next beat to be loaded into the output register
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] bar_left;
  logic [2:0]       bar_idx;
  logic             gen_done;
  logic             out_eof;
  logic [CH_W-1:0]  frame_cnt;

  logic [CNT_W-1:0] h_last_in;
  logic [CNT_W-1:0] v_last_in;
  logic [CNT_W-1:0] bar_w_in;
  logic [CNT_W-1:0] bar_w_m1_in;

  assign h_last_in   = h_res - CNT_W'(1);
  assign v_last_in   = v_res - CNT_W'(1);
  assign bar_w_in    = h_res >> 3;
  assign bar_w_m1_in = (bar_w_in == '0) ? '0 : bar_w_in - CNT_W'(1);
  assign cfg_ok      = (h_res != '0) && (v_res != '0);
  assign accept      = pix_tvalid && pix_tready;
  assign busy        = (state == RUN);

`ifdef PATTERN_GEN_CONTINUOUS_EN
  assign cont_req = continuous;
`else
  assign cont_req = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    restart   = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (sof && cfg_ok) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && out_eof) begin
          frame_end = 1'b1;
          if (cont_req && cfg_ok) restart   = 1'b1;
          else                    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load = (state == RUN) && (!pix_tvalid || pix_tready) && (restart || !gen_done);

  // On a continuous restart the first beat of the next frame is built straight from the
  // inputs so it can load on the same edge the previous frame's last beat is accepted.
  logic [CNT_W-1:0] src_h;
  logic [CNT_W-1:0] src_v;
  logic [CNT_W-1:0] src_h_last;
  logic [CNT_W-1:0] src_v_last;
  logic [CNT_W-1:0] src_bar_left;
  logic [CNT_W-1:0] src_bar_w_m1;
  logic [2:0]       src_bar_idx;
  mode_e            src_mode;
  logic [PIX_W-1:0] src_solid;
  logic [CH_W-1:0]  src_frame;
  logic             src_eol;
  logic             src_eof;
  logic [PIX_W-1:0] pixel;

  always_comb begin
    if (restart) begin
      src_h        = '0;
      src_v        = '0;
      src_h_last   = h_last_in;
      src_v_last   = v_last_in;
      src_bar_left = bar_w_m1_in;
      src_bar_w_m1 = bar_w_m1_in;
      src_bar_idx  = '0;
      src_mode     = mode_e'(mode);
      src_solid    = solid_color;
      src_frame    = frame_cnt + CH_W'(1);
    end else begin
      src_h        = h_cnt;
      src_v        = v_cnt;
      src_h_last   = h_last_q;
      src_v_last   = v_last_q;
      src_bar_left = bar_left;
      src_bar_w_m1 = bar_w_m1_q;
      src_bar_idx  = bar_idx;
      src_mode     = mode_q;
      src_solid    = solid_q;
      src_frame    = frame_cnt;
    end
  end

  assign src_eol = (src_h == src_h_last);
  assign src_eof = src_eol && (src_v == src_v_last);

  pattern_gen_pixel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) u_pixel (
    .mode        (src_mode),
    .h_cnt       (src_h),
    .v_cnt       (src_v),
    .h_last      (src_h_last),
    .v_last      (src_v_last),
    .bar_idx     (src_bar_idx),
    .frame_cnt   (src_frame),
    .solid_color (src_solid),
    .pixel       (pixel)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q     <= MODE_RAMP;
      solid_q    <= '0;
      h_last_q   <= '0;
      v_last_q   <= '0;
      bar_w_m1_q <= '0;
    end else if (start || restart) begin
      mode_q     <= mode_e'(mode);
      solid_q    <= solid_color;
      h_last_q   <= h_last_in;
      v_last_q   <= v_last_in;
      bar_w_m1_q <= bar_w_m1_in;
    end
  end

  // bar_left counts down the pixels remaining in the current bar after this one
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      bar_left <= '0;
      bar_idx  <= '0;
      gen_done <= 1'b0;
    end else if (start) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      bar_left <= bar_w_m1_in;
      bar_idx  <= '0;
      gen_done <= 1'b0;
    end else if (load) begin
      gen_done <= src_eof;
      if (src_eol) begin
        h_cnt    <= '0;
        v_cnt    <= src_eof ? src_v : src_v + CNT_W'(1);
        bar_left <= src_bar_w_m1;
        bar_idx  <= '0;
      end else begin
        h_cnt <= src_h + CNT_W'(1);
        v_cnt <= src_v;
        if (src_bar_left == '0) begin
          bar_left <= src_bar_w_m1;
          bar_idx  <= (src_bar_idx == 3'd7) ? 3'd7 : src_bar_idx + 3'd1;
        end else begin
          bar_left <= src_bar_left - CNT_W'(1);
          bar_idx  <= src_bar_idx;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_tvalid <= 1'b0;
      pix_tdata  <= '0;
      pix_tlast  <= 1'b0;
      pix_tuser  <= 1'b0;
      out_eof    <= 1'b0;
    end else if (load) begin
      pix_tvalid <= 1'b1;
      pix_tdata  <= pixel;
      pix_tlast  <= src_eol;
      pix_tuser  <= (src_h == '0) && (src_v == '0);
      out_eof    <= src_eof;
    end else if (accept) begin
      pix_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + CH_W'(1);
    end
  end

endmodule
